icon_xfer_engine: RTL and testbench
===================================

ICON_XFER_ENGINE -- requirements
Module: icon_xfer_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning request FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter RETRY_LIMIT, default 15, meaning the maximum number of READ cycles without icon_rsuccess_i before the request is dropped.
REQ-003 SHALL have port clk  in  1  the single clock; reset is synchronous and active-high.
REQ-004 SHALL have port reset  in  1  synchronous active-high reset.
REQ-005 SHALL have port req_valid_i  in  1  transfer request valid.
REQ-006 SHALL have port req_ready_o  out  1  request accepted when high with req_valid_i.
REQ-007 SHALL have port req_src_addr_i  in  type_exec_unit_addr  operand address in the source EU tx buffer.
REQ-008 SHALL have port req_dst_port_i  in  1  destination channel (0=w0/op0, 1=w1/op1).
REQ-009 SHALL have port icon_raddr_o  out  type_exec_unit_addr  read address to the source EU.
REQ-010 SHALL have port icon_rvalid_o  out  1  read request valid.
REQ-011 SHALL have port icon_rdata_i  in  type_exec_unit_data  read data from the source EU.
REQ-012 SHALL have port icon_rsuccess_i  in  1  read hit; icon_rdata_i is valid in the same cycle.
REQ-013 SHALL have ports icon_w0_o / icon_w1_o  out  type_icon_tx_channel  addr/valid/data writes to the destination EU op0/op1 buffers.
REQ-014 SHALL have ports icon_w0_rx_i / icon_w1_rx_i  in  type_icon_rx_channel  the .success write acknowledges.
REQ-015 SHALL have port err_o  out  1  one-cycle pulse when a request is dropped on timeout.
REQ-016 SHALL have port busy_o  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
REQ-017 SHALL have port xfer_count_o  out  16  number of completed transfers.

Function
REQ-018 SHALL accept a request into the FIFO when req_valid_i & req_ready_o are both high; req_ready_o = ~full, with no bypass path.
REQ-019 SHALL implement a registered FSM with states IDLE, READ and WRITE.
REQ-020 SHALL, in IDLE with the FIFO non-empty, pop the head into the current-request register and enter READ on the next cycle, so icon_rvalid_o rises no earlier than 2 cycles after acceptance.
REQ-021 SHALL, in READ, drive icon_rvalid_o=1 and icon_raddr_o=current src addr, held stable until success or timeout.
REQ-022 SHALL, on icon_rsuccess_i in READ, capture icon_rdata_i and enter WRITE; the retry counter resets to 0.
REQ-023 SHALL, in READ without success, increment the retry counter; when the counter reaches RETRY_LIMIT, pulse err_o for one cycle, drop the request and leave READ as in REQ-025.
REQ-024 SHALL, in WRITE, assert only the selected channel's valid with addr=current src addr and data=captured data, held stable until its .success; the unselected channel's valid SHALL stay 0; there is no timeout in WRITE.
REQ-025 SHALL, on write success or a timeout drop, pop the next head and go directly to READ if the FIFO is non-empty, otherwise go to IDLE.
REQ-026 SHALL increment xfer_count_o by 1 on each write success, wrapping from 0xFFFF to 0.
REQ-027 SHALL ensure that a simultaneous push and pop in one cycle keeps the occupancy unchanged; a push while full is refused.
REQ-028 SHALL keep icon_rvalid_o and both write valids at 0 in IDLE; the read and write valids are never high together.

Reset
REQ-029 SHALL, while reset is high, set on the next clk edge: FSM=IDLE, FIFO empty, retry counter=0, xfer_count_o=0, err_o=0, all valids=0, addr/data outputs=0, req_ready_o=1.
REQ-030 SHALL, on reset mid-transfer, abandon the in-flight and queued requests without issuing any further read or write.

Structure
REQ-031 SHALL take type_exec_unit_addr, type_exec_unit_data, type_icon_tx_channel and type_icon_rx_channel from pkg_dtypes, and add the FSM state enum type_xfer_state to pkg_dtypes.
REQ-032 SHALL put the request FIFO in one sub-module, icon_xfer_fifo, a synchronous FIFO parameterised by width and depth with full/empty outputs.

Verification
REQ-033 SHALL cover a single transfer: request src addr 0x12, port 0; source gives rsuccess on its first READ cycle with data 0xA5A5 -> icon_w0_o carries addr 0x12 and data 0xA5A5; after success, xfer_count_o=1 and the FSM is IDLE.
REQ-034 SHALL cover read stall: rsuccess withheld for 5 cycles -> icon_rvalid_o stays high with a stable address for 6 cycles and err_o stays 0.
REQ-035 SHALL cover timeout: rsuccess never given -> err_o pulses once after 15 READ cycles, xfer_count_o is unchanged, and the next request starts.
REQ-036 SHALL cover full FIFO: 5 back-to-back requests while the first write is stalled -> req_ready_o drops after 4 entries, and all accepted requests complete in order on the correct ports.
REQ-037 SHALL cover port select with write backpressure: port 1 with w1 success delayed 3 cycles -> w1 valid is held for 4 cycles and w0 valid stays 0 throughout.
REQ-038 SHALL cover reset mid-WRITE: reset pulsed while a write and 2 entries are pending -> all valids are 0 the next cycle, xfer_count_o=0, and no further activity follows.

Source files
------------

// File: rtl/pkg_dtypes.sv
// Shared datapath types for the interconnect transfer engine and its request FIFO.
// Pure declarations; no timing or backpressure of their own.
package pkg_dtypes;

    localparam int EU_ADDR_W = 8;
    localparam int EU_DATA_W = 16;

    typedef logic [EU_ADDR_W-1:0] type_exec_unit_addr;
    typedef logic [EU_DATA_W-1:0] type_exec_unit_data;

    typedef struct packed {
        type_exec_unit_addr addr;
        logic               valid;
        type_exec_unit_data data;
    } type_icon_tx_channel;

    typedef struct packed {
        logic success;
    } type_icon_rx_channel;

    typedef enum logic [1:0] {
        XFER_IDLE  = 2'd0,
        XFER_READ  = 2'd1,
        XFER_WRITE = 2'd2
    } type_xfer_state;

    typedef struct packed {
        type_exec_unit_addr src_addr;
        logic               dst_port;
    } type_xfer_req;

    // A disabled channel drives all-zero so idle buses stay quiet.
    function automatic type_icon_tx_channel tx_drive(input logic en,
                                                     input type_exec_unit_addr addr,
                                                     input type_exec_unit_data data);
        type_icon_tx_channel ch;
        ch = '0;
        if (en) begin
            ch.addr  = addr;
            ch.valid = 1'b1;
            ch.data  = data;
        end
        return ch;
    endfunction

endpackage

// File: rtl/icon_xfer_fifo.sv
// Synchronous request FIFO; head visible combinationally, one-cycle push-to-head latency.
// Push refused while full, pop ignored while empty; simultaneous push/pop keeps occupancy.
module icon_xfer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push_vld & ~full;
    assign do_pop   = pop_rdy & ~empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/icon_xfer_engine.sv
// Moves operands from a source EU tx buffer to a destination EU op0/op1 buffer via READ then WRITE.
// Read starts 2 cycles after acceptance; req_ready_o drops only when the request FIFO is full.
module icon_xfer_engine
    import pkg_dtypes::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int RETRY_LIMIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  type_exec_unit_addr  req_src_addr_i,
    input  logic                req_dst_port_i,
    output type_exec_unit_addr  icon_raddr_o,
    output logic                icon_rvalid_o,
    input  type_exec_unit_data  icon_rdata_i,
    input  logic                icon_rsuccess_i,
    output type_icon_tx_channel icon_w0_o,
    output type_icon_tx_channel icon_w1_o,
    input  type_icon_rx_channel icon_w0_rx_i,
    input  type_icon_rx_channel icon_w1_rx_i,
    output logic                err_o,
    output logic                busy_o,
    output logic [15:0]         xfer_count_o
);

    localparam int RW = $clog2(RETRY_LIMIT + 1);

    type_xfer_state     state;
    type_xfer_req       req_in;
    type_xfer_req       head;
    type_xfer_req       cur;
    type_exec_unit_data rd_buf;
    logic [RW-1:0]      retry;
    logic [15:0]        xfer_count;
    logic               err;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               rd_done;
    logic               rd_timeout;
    logic               wr_done;

    assign req_in = '{src_addr: req_src_addr_i, dst_port: req_dst_port_i};

    icon_xfer_fifo #(
        .WIDTH ($bits(type_xfer_req)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (req_valid_i),
        .push_dat (req_in),
        .pop_rdy  (pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rd_done    = (state == XFER_READ) && icon_rsuccess_i;
    assign rd_timeout = (state == XFER_READ) && !icon_rsuccess_i && (retry == RW'(RETRY_LIMIT - 1));
    assign wr_done    = (state == XFER_WRITE) &&
                        (cur.dst_port ? icon_w1_rx_i.success : icon_w0_rx_i.success);

    // The next request is loaded on the same edge the current one retires.
    assign pop = !fifo_empty && ((state == XFER_IDLE) || rd_timeout || wr_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= XFER_IDLE;
            cur        <= '0;
            rd_buf     <= '0;
            retry      <= '0;
            xfer_count <= '0;
            err        <= 1'b0;
        end else begin
            err <= rd_timeout;
            if (pop) begin
                cur <= head;
            end
            case (state)
                XFER_IDLE: begin
                    if (!fifo_empty) begin
                        state <= XFER_READ;
                    end
                end
                XFER_READ: begin
                    if (rd_done) begin
                        rd_buf <= icon_rdata_i;
                        retry  <= '0;
                        state  <= XFER_WRITE;
                    end else if (rd_timeout) begin
                        retry <= '0;
                        state <= fifo_empty ? XFER_IDLE : XFER_READ;
                    end else begin
                        retry <= retry + RW'(1);
                    end
                end
                XFER_WRITE: begin
                    if (wr_done) begin
                        xfer_count <= xfer_count + 16'd1;
                        state      <= fifo_empty ? XFER_IDLE : XFER_READ;
                    end
                end
                default: state <= XFER_IDLE;
            endcase
        end
    end

    assign req_ready_o   = ~fifo_full;
    assign icon_rvalid_o = (state == XFER_READ);
    assign icon_raddr_o  = icon_rvalid_o ? cur.src_addr : '0;
    assign icon_w0_o     = tx_drive((state == XFER_WRITE) && !cur.dst_port, cur.src_addr, rd_buf);
    assign icon_w1_o     = tx_drive((state == XFER_WRITE) &&  cur.dst_port, cur.src_addr, rd_buf);
    assign err_o         = err;
    assign busy_o        = (state != XFER_IDLE) || !fifo_empty;
    assign xfer_count_o  = xfer_count;

endmodule

// File: tb/tb_icon_xfer_engine.sv
// Directed and randomized checks of icon_xfer_engine against a transaction-level model.
module tb_icon_xfer_engine;
    import pkg_dtypes::*;

    localparam int RETRY = 15;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    type_exec_unit_addr  req_addr;
    logic                req_port;
    type_exec_unit_addr  raddr;
    logic                rvalid;
    type_exec_unit_data  rdata;
    logic                rsuccess;
    type_icon_tx_channel w0;
    type_icon_tx_channel w1;
    type_icon_rx_channel w0_rx;
    type_icon_rx_channel w1_rx;
    logic                err;
    logic                busy;
    logic [15:0]         xfer_count;

    always #5 clk = ~clk;

    icon_xfer_engine #(.FIFO_DEPTH(4), .RETRY_LIMIT(RETRY)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_src_addr_i  (req_addr),
        .req_dst_port_i  (req_port),
        .icon_raddr_o    (raddr),
        .icon_rvalid_o   (rvalid),
        .icon_rdata_i    (rdata),
        .icon_rsuccess_i (rsuccess),
        .icon_w0_o       (w0),
        .icon_w1_o       (w1),
        .icon_w0_rx_i    (w0_rx),
        .icon_w1_rx_i    (w1_rx),
        .err_o           (err),
        .busy_o          (busy),
        .xfer_count_o    (xfer_count)
    );

    // A request plus the responder behaviour the bench will apply to it.
    typedef struct {
        int addr;
        int port;
        int rd_dly;
        int wr_dly;
    } req_t;

    req_t        exp_q[$];
    req_t        cur;
    req_t        pend;
    logic [15:0] mem [256];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          phase = 0;
    int          rd_cyc = 0;
    int          wr_cyc = 0;
    int          wait_cyc = 0;
    int          last_rd = 0;
    int          last_wr = 0;
    int          last_to = 0;
    int          err_seen = 0;
    int          done_exp = 0;
    int          to_exp = 0;
    logic        err_exp = 1'b0;
    logic [15:0] model_cnt = 16'd0;
    logic        acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle at the negedge: check outputs against the model, answer the DUT, advance.
    task automatic tick();
        type_icon_tx_channel sel;
        type_icon_tx_channel oth;
        logic                any_w;
        chk("err_pulse", 32'(err), 32'(err_exp));
        if (err === 1'b1) err_seen++;
        err_exp = 1'b0;
        chk("xfer_count", 32'(xfer_count), 32'(model_cnt));
        rsuccess      = 1'b0;
        rdata         = 16'($urandom);
        w0_rx.success = 1'b0;
        w1_rx.success = 1'b0;
        any_w = w0.valid | w1.valid;
        if (phase == 0 && exp_q.size() != 0) begin
            if (wait_cyc >= 1) chk("start_latency", 32'(rvalid), 32'd1);
            if (rvalid === 1'b1) begin
                cur      = exp_q.pop_front();
                phase    = 1;
                rd_cyc   = 0;
                wait_cyc = 0;
            end else begin
                wait_cyc++;
            end
        end else if (phase == 0) begin
            chk("spurious_read", 32'(rvalid), 32'd0);
        end
        if (phase == 1) begin
            chk("rvalid_hold", 32'(rvalid), 32'd1);
            chk("raddr", 32'(raddr), 32'(cur.addr));
            chk("wvalid_in_read", 32'(any_w), 32'd0);
            if (rd_cyc == cur.rd_dly) begin
                rsuccess = 1'b1;
                rdata    = mem[cur.addr];
                phase    = 2;
                wr_cyc   = 0;
                last_rd  = rd_cyc + 1;
            end else if (rd_cyc == RETRY - 1) begin
                err_exp = 1'b1;
                phase   = 0;
                last_to = rd_cyc + 1;
            end
            rd_cyc++;
        end else if (phase == 2) begin
            sel = (cur.port != 0) ? w1 : w0;
            oth = (cur.port != 0) ? w0 : w1;
            chk("wvalid_sel", 32'(sel.valid), 32'd1);
            chk("wvalid_other", 32'(oth.valid), 32'd0);
            chk("rvalid_in_write", 32'(rvalid), 32'd0);
            chk("waddr", 32'(sel.addr), 32'(cur.addr));
            chk("wdata", 32'(sel.data), 32'(mem[cur.addr]));
            if (cur.port != 0) w0_rx.success = 1'($urandom);
            else               w1_rx.success = 1'($urandom);
            if (wr_cyc == cur.wr_dly) begin
                if (cur.port != 0) w1_rx.success = 1'b1;
                else               w0_rx.success = 1'b1;
                model_cnt = model_cnt + 16'd1;
                phase     = 0;
                last_wr   = wr_cyc + 1;
            end
            wr_cyc++;
        end else begin
            chk("idle_wvalid", 32'(any_w), 32'd0);
            if (rvalid === 1'b0) rsuccess = 1'($urandom);
        end
        acc = req_valid && req_ready;
        if (acc) exp_q.push_back(pend);
        @(negedge clk);
    endtask

    task automatic drive_req(input int a, input int p, input int rd, input int wr);
        pend      = '{a, p, rd, wr};
        req_addr  = 8'(a);
        req_port  = 1'(p);
        req_valid = 1'b1;
        if (rd < RETRY) done_exp++;
        else            to_exp++;
    endtask

    task automatic present(input int a, input int p, input int rd, input int wr);
        int k;
        drive_req(a, p, rd, wr);
        acc = 1'b0;
        k = 0;
        while (!acc && k < 100) begin
            tick();
            k++;
        end
        chk("accept", 32'(acc), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (k < 3000 && !(phase == 0 && exp_q.size() == 0 && err_exp == 1'b0 &&
                             rvalid === 1'b0 && (w0.valid | w1.valid) === 1'b0)) begin
            tick();
            k++;
        end
        chk("drain_bound", 32'(k < 3000), 32'd1);
    endtask

    initial begin
        int e0;
        int k;
        int rd;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_port  = 1'b0;
        rdata     = '0;
        rsuccess  = 1'b0;
        w0_rx     = '0;
        w1_rx     = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h12] = 16'hA5A5;
        repeat (3) @(negedge clk);

        // Reset state, sampled while reset is still asserted.
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_w0", 32'(w0), 32'd0);
        chk("rst_w1", 32'(w1), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_xfer", 32'(xfer_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single transfer: addr 0x12 to port 0, immediate read hit.
        drive_req(8'h12, 0, 0, 0);
        chk("t1_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("t1_rvalid_lat1", 32'(rvalid), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_rvalid_lat2", 32'(rvalid), 32'd1);
        chk("t1_raddr", 32'(raddr), 32'h12);
        tick();
        chk("t1_w0_valid", 32'(w0.valid), 32'd1);
        chk("t1_w0_addr", 32'(w0.addr), 32'h12);
        chk("t1_w0_data", 32'(w0.data), 32'hA5A5);
        chk("t1_w1_valid", 32'(w1.valid), 32'd0);
        tick();
        chk("t1_xfer", 32'(xfer_count), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_w0_clear", 32'(w0.valid), 32'd0);

        // Read stall of 5 cycles, then the longest stall that still succeeds.
        e0 = err_seen;
        present(8'h20, 1, 5, 0);
        drain();
        chk("stall_rd_cycles", 32'(last_rd), 32'd6);
        present(8'h21, 0, 14, 1);
        drain();
        chk("stall14_rd_cycles", 32'(last_rd), 32'd15);
        chk("stall14_wr_cycles", 32'(last_wr), 32'd2);
        chk("stall_no_err", 32'(err_seen - e0), 32'd0);
        chk("stall_xfer", 32'(xfer_count), 32'(done_exp));

        // Timeout with a second request queued behind it.
        e0 = err_seen;
        present(8'h30, 0, 99, 0);
        present(8'h31, 1, 0, 0);
        drain();
        chk("timeout_err_count", 32'(err_seen - e0), 32'd1);
        chk("timeout_cycles", 32'(last_to), 32'd15);
        chk("timeout_xfer", 32'(xfer_count), 32'(done_exp));

        // Fill the FIFO while the first write is held off.
        present(8'h50, 0, 0, 15);
        k = 0;
        while (phase != 2 && k < 50) begin
            tick();
            k++;
        end
        chk("full_reach_write", 32'(phase), 32'd2);
        for (int i = 0; i < 5; i++) begin
            drive_req(8'h60 + i, i % 2, i, 1);
            chk("full_ready", 32'(req_ready), 32'(i < 4));
            chk("full_busy", 32'(busy), 32'd1);
            tick();
        end
        k = 0;
        while (!acc && k < 100) begin
            tick();
            k++;
        end
        chk("full_accept_last", 32'(acc), 32'd1);
        req_valid = 1'b0;
        drain();
        chk("full_xfer", 32'(xfer_count), 32'(done_exp));
        chk("full_ready_after", 32'(req_ready), 32'd1);

        // Port 1 with a write acknowledge delayed by 3 cycles.
        present(8'h40, 1, 1, 3);
        drain();
        chk("p1_wr_cycles", 32'(last_wr), 32'd4);
        chk("p1_rd_cycles", 32'(last_rd), 32'd2);

        // Randomized traffic including timeouts.
        for (int i = 0; i < 25; i++) begin
            rd = ($urandom_range(0, 5) == 0) ? 15 + int'($urandom_range(0, 4))
                                             : int'($urandom_range(0, 3));
            present(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), rd,
                    int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        chk("rand_xfer", 32'(xfer_count), 32'(done_exp));
        chk("rand_err", 32'(err_seen), 32'(to_exp));

        // Reset during a stalled write with two requests queued.
        present(8'h70, 0, 0, 20);
        present(8'h71, 1, 0, 0);
        present(8'h72, 0, 0, 0);
        chk("mid_phase_write", 32'(phase), 32'd2);
        chk("mid_w0_valid", 32'(w0.valid), 32'd1);
        reset     = 1'b1;
        rsuccess  = 1'b0;
        w0_rx     = '0;
        w1_rx     = '0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_w0", 32'(w0), 32'd0);
        chk("mid_rst_w1", 32'(w1), 32'd0);
        chk("mid_rst_xfer", 32'(xfer_count), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        phase     = 0;
        wait_cyc  = 0;
        model_cnt = 16'd0;
        err_exp   = 1'b0;
        done_exp  = 0;
        repeat (25) tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // The engine still works after being reset mid-flight.
        present(8'h7A, 1, 2, 1);
        drain();
        chk("post_rst_xfer", 32'(xfer_count), 32'(done_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
